// File: rtl/fifo_pkg.sv
// Shared constants and default threshold helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int default_af_level(input int addr_width);
    return (1 << addr_width) - 2;
  endfunction

  // Shallow FIFOs cannot honour a threshold of 2, so clamp below depth.
  function automatic int default_ae_level(input int addr_width);
    return ((1 << addr_width) > 3) ? 2 : (1 << addr_width) - 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctl_sdp_ram.sv
// Simple dual-port RAM with a registered read port; a read colliding with a
// write to the same address returns the old contents.
module sdp_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller: pointers, occupancy, registered flags, sticky
// errors and an optional first-word-fall-through prefetch stage.
module sync_fifo_ctl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_LEVEL   = default_af_level(ADDR_WIDTH),
  parameter int AE_LEVEL   = default_ae_level(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);
  localparam logic                AF_RST  = (AF_LEVEL == 0);

  if (AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_param_check
    $error("sync_fifo_ctl: AF_LEVEL must be <= DEPTH and AE_LEVEL < DEPTH");
  end

  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [ADDR_WIDTH:0]   level_nxt;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr_ok, rd_ok, ram_re;

  assign wr_ok = we & ~full;
  assign rd_ok = re & ~empty;

  always_comb begin
    level_nxt = level;
    if (wr_ok && !rd_ok)      level_nxt = level + ONE_L;
    else if (rd_ok && !wr_ok) level_nxt = level - ONE_L;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr        <= '0;
      raddr        <= '0;
      level        <= '0;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= AF_RST;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (clr) begin
      waddr        <= '0;
      raddr        <= '0;
      level        <= '0;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= AF_RST;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok)  waddr <= waddr + ADDR_WIDTH'(1);
      if (ram_re) raddr <= raddr + ADDR_WIDTH'(1);
      level        <= level_nxt;
      full         <= (level_nxt == DEPTH_L);
      almost_empty <= (level_nxt <= AE_L);
      almost_full  <= (level_nxt >= AF_L);
      if (we && full)  overflow  <= 1'b1;
      if (re && empty) underflow <= 1'b1;
    end
  end

  sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(waddr),
    .wdata(d),
    .re   (ram_re),
    .raddr(raddr),
    .rdata(rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    logic                  pend, out_valid;
    logic [DATA_WIDTH-1:0] out_reg;
    logic [ADDR_WIDTH:0]   ram_cnt;

    // Words still sitting in RAM, excluding the in-flight read and the head.
    assign ram_cnt = level - {{ADDR_WIDTH{1'b0}}, out_valid} - {{ADDR_WIDTH{1'b0}}, pend};
    // Only fetch when the output register is guaranteed free at the load edge.
    assign ram_re  = (ram_cnt != '0) & ~pend & (~out_valid | rd_ok);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend      <= 1'b0;
        out_valid <= 1'b0;
        out_reg   <= '0;
      end else if (clr) begin
        pend      <= 1'b0;
        out_valid <= 1'b0;
        out_reg   <= '0;
      end else begin
        pend <= ram_re;
        if (pend) begin
          out_reg   <= rdata;
          out_valid <= 1'b1;
        end else if (rd_ok) begin
          out_valid <= 1'b0;
        end
      end
    end

    assign empty = ~out_valid;
    assign q     = out_reg;
  end else begin : g_std
    logic rd_valid, empty_r;

    assign ram_re = rd_ok;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_valid <= 1'b0;
        empty_r  <= 1'b1;
      end else if (clr) begin
        rd_valid <= 1'b0;
        empty_r  <= 1'b1;
      end else begin
        if (rd_ok) rd_valid <= 1'b1;
        empty_r <= (level_nxt == '0);
      end
    end

    // RAM output is unreset, so mask it until the first accepted read.
    assign empty = empty_r;
    assign q     = rd_valid ? rdata : '0;
  end

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Self-checking bench for sync_fifo_ctl in standard and FWFT modes.
module tb_sync_fifo_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        clr = 1'b0, we = 1'b0, re = 1'b0;
  logic [15:0] d = '0, q;
  logic        empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0]  level;

  logic        clr_f = 1'b0, we_f = 1'b0, re_f = 1'b0;
  logic [15:0] d_f = '0, q_f;
  logic        empty_f, full_f, ae_f, af_f, ovf_f, unf_f;
  logic [4:0]  level_f;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] sb[$];
  logic [15:0] sbf[$];
  int          lvl_m = 0;
  logic [15:0] q_m = '0;
  logic        ovf_m = 1'b0, unf_m = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_ctl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) dut_std (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .d(d), .re(re), .q(q),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_ctl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) dut_fwft (
    .clk(clk), .rst(rst), .clr(clr_f), .we(we_f), .d(d_f), .re(re_f), .q(q_f),
    .empty(empty_f), .full(full_f), .almost_empty(ae_f), .almost_full(af_f),
    .level(level_f), .overflow(ovf_f), .underflow(unf_f)
  );

  typedef struct {
    logic        we, re, clr;
    logic [15:0] d;
    logic [15:0] q;
    int          level;
    logic [5:0]  flags;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] flags_m();
    return {lvl_m == 0, lvl_m == 16, lvl_m <= 2, lvl_m >= 14, ovf_m, unf_m};
  endfunction

  task automatic chk_std(input string tag);
    chk({tag, " q"}, 32'(q), 32'(q_m));
    chk({tag, " level"}, 32'(level), 32'(lvl_m));
    chk({tag, " flags"}, 32'({empty, full, almost_empty, almost_full, overflow, underflow}), 32'(flags_m()));
  endtask

  task automatic model_clear();
    sb.delete();
    lvl_m = 0;
    q_m   = '0;
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endtask

  task automatic cyc(input string tag, input logic w, input logic [15:0] dv, input logic r);
    bit wok, rok;
    wok = w && (lvl_m < 16);
    rok = r && (lvl_m > 0);
    if (w && !wok) ovf_m = 1'b1;
    if (r && !rok) unf_m = 1'b1;
    if (rok) q_m = sb.pop_front();
    if (wok) sb.push_back(dv);
    lvl_m = lvl_m + int'(wok) - int'(rok);
    we = w; d = dv; re = r;
    step();
    we = 1'b0; re = 1'b0;
    chk_std(tag);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_clear();
    chk_std("clr");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{we:1'b0, re:1'b1, clr:1'b0, d:16'h0000, q:16'h0000, level:0, flags:6'b101001};
    vecs[1] = '{we:1'b1, re:1'b0, clr:1'b0, d:16'h0A01, q:16'h0000, level:1, flags:6'b001001};
    vecs[2] = '{we:1'b1, re:1'b0, clr:1'b0, d:16'h0A02, q:16'h0000, level:2, flags:6'b001001};
    vecs[3] = '{we:1'b1, re:1'b0, clr:1'b0, d:16'h0A03, q:16'h0000, level:3, flags:6'b000001};
    vecs[4] = '{we:1'b1, re:1'b1, clr:1'b0, d:16'h0A04, q:16'h0A01, level:3, flags:6'b000001};
    vecs[5] = '{we:1'b1, re:1'b1, clr:1'b1, d:16'h0A05, q:16'h0000, level:0, flags:6'b101000};
    vecs[6] = '{we:1'b1, re:1'b1, clr:1'b0, d:16'h0A06, q:16'h0000, level:1, flags:6'b001001};
    vecs[7] = '{we:1'b0, re:1'b0, clr:1'b1, d:16'h0000, q:16'h0000, level:0, flags:6'b101000};

    step();
    step();
    rst = 1'b0;
    step();
    chk_std("reset std");
    chk("reset fwft empty", 32'(empty_f), 32'(1));
    chk("reset fwft level", 32'(level_f), 32'(0));

    for (int i = 0; i < 8; i++) begin
      we = vecs[i].we; re = vecs[i].re; clr = vecs[i].clr; d = vecs[i].d;
      step();
      we = 1'b0; re = 1'b0; clr = 1'b0;
      chk($sformatf("vec%0d q", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].level));
      chk($sformatf("vec%0d flags", i), 32'({empty, full, almost_empty, almost_full, overflow, underflow}),
          32'(vecs[i].flags));
    end
    model_clear();

    for (int i = 1; i <= 17; i++) cyc($sformatf("fill%0d", i), 1'b1, 16'(i), 1'b0);
    for (int i = 1; i <= 17; i++) cyc($sformatf("drain%0d", i), 1'b0, 16'h0, 1'b1);
    do_clr();

    for (int i = 0; i < 8; i++) cyc("pre8", 1'b1, 16'h0100 + 16'(i), 1'b0);
    for (int i = 0; i < 20; i++) cyc($sformatf("simul%0d", i), 1'b1, 16'h0200 + 16'(i), 1'b1);
    for (int i = 0; i < 8; i++) cyc("post8", 1'b0, 16'h0, 1'b1);

    for (int i = 0; i < 9; i++) cyc("pre_rst", 1'b1, 16'h0300 + 16'(i), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    chk_std("async rst");
    #1;
    rst = 1'b0;
    step();
    cyc("post_rst wr", 1'b1, 16'h1234, 1'b0);
    cyc("post_rst rd", 1'b0, 16'h0, 1'b1);

    we_f = 1'b1; d_f = 16'hABCD;
    step();
    we_f = 1'b0;
    chk("fwft N empty", 32'(empty_f), 32'(1));
    chk("fwft N level", 32'(level_f), 32'(1));
    step();
    chk("fwft N+1 empty", 32'(empty_f), 32'(1));
    step();
    chk("fwft N+2 empty", 32'(empty_f), 32'(0));
    chk("fwft N+2 q", 32'(q_f), 32'(16'hABCD));
    chk("fwft N+2 level", 32'(level_f), 32'(1));
    re_f = 1'b1;
    step();
    re_f = 1'b0;
    chk("fwft pop empty", 32'(empty_f), 32'(1));
    chk("fwft pop level", 32'(level_f), 32'(0));

    for (int i = 0; i < 4; i++) begin
      we_f = 1'b1; d_f = 16'hC000 + 16'(i);
      sbf.push_back(d_f);
      step();
    end
    we_f = 1'b0;
    for (int c = 0; c < 40 && sbf.size() > 0; c++) begin
      if (!empty_f) begin
        chk("fwft order q", 32'(q_f), 32'(sbf.pop_front()));
        re_f = 1'b1;
      end else begin
        re_f = 1'b0;
      end
      step();
    end
    re_f = 1'b0;
    chk("fwft drained", 32'(sbf.size()), 32'(0));
    step();
    chk("fwft end flags", 32'({empty_f, level_f, ovf_f, unf_f}), 32'({1'b1, 5'd0, 1'b0, 1'b0}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
